// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Direct-mapped, write-back, write-allocate L1 data cache with miss stall.
// Optional DCACHE_STATS_EN adds saturating access/miss counters.
// Revision : 1.0
// ============================================================================
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       access_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_W / 32);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [LINE_W-1:0]    mem_wdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] line_d;
  logic              hit;
  logic              idle_req;
  logic              load_hit;
  logic              store_hit;
  logic              miss;
  logic              fill_done;
  logic              unused_byte_off;

  assign idx  = cpu_addr_i[OFF_W +: IDX_W];
  assign tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel = cpu_addr_i[OFF_W-1 -: WSEL_W];
  assign line = data_q[idx];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  assign unused_byte_off = ^cpu_addr_i[OFF_W-WSEL_W-1:0];

  assign idle_req  = (state_q == S_IDLE) && cpu_req_i;
  assign load_hit  = idle_req && hit && !cpu_we_i;
  assign store_hit = idle_req && hit && cpu_we_i;
  assign miss      = idle_req && !hit;
  assign fill_done = (state_q == S_ALLOCATE) && mem_ack_i;

  // Store data merged into the resident line
  always_comb begin
    line_d                   = line;
    line_d[{wsel, 5'b0} +: 32] = cpu_wdata_i;
  end

  assign cpu_rdata_o = load_hit ? line[{wsel, 5'b0} +: 32] : 32'd0;
  assign cpu_stall_o = (state_q != S_IDLE) || miss;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end else if (miss) begin
            mem_req_q <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q     <= S_WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
              mem_wdata_q <= line;
            end else begin
              state_q    <= S_ALLOCATE;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q    <= S_ALLOCATE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; a fill racing reset is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (store_hit) begin
        data_q[idx] <= line_d;
      end else if (fill_done) begin
        data_q[idx] <= mem_rdata_i;
        tag_q[idx]  <= tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] access_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      access_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      if (cpu_req_i && !cpu_stall_o && (access_cnt_q != 32'hFFFF_FFFF))
        access_cnt_q <= access_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign access_cnt_o = access_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Randomized bench for dcache_controller against an architectural memory model.
// Revision : 1.0
// ============================================================================
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  access_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .access_cnt_o(access_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Architectural view: last stored value per word, else the backing memory
  logic [31:0] shadow    [logic [31:0]];
  logic [31:0] mem_model [logic [31:0]];
  // Which line each set currently holds, as the CPU would reason about it
  bit          res_valid [32];
  bit          res_dirty [32];
  logic [21:0] res_tag   [32];
  logic [32:0] txn_q [$];
  bit          resp_en;
  int          exp_acc;
  int          exp_miss;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : mem_word(a);
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_word({a[31:5], 5'b0} + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word({a[31:5], 5'b0} + 32'(i * 4));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_tag[i]   = '0;
    end
    shadow.delete();
    exp_acc  = 0;
    exp_miss = 0;
  endtask

  // Slow memory: random ack latency, writes back into mem_model
  initial begin : responder
    logic [31:0]  a;
    logic [255:0] d;
    logic         w;
    int           lat;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o && !rst_i && resp_en) begin
        a = mem_addr_o;
        w = mem_we_o;
        d = mem_wdata_o;
        txn_q.push_back({w, a});
        if (w) chk("wb_data", d, arch_line(a));
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk_i);
          chk("req_held", 256'({mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b1, w, a}));
        end
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = w ? '0 : mem_line(a);
        if (w) for (int i = 0; i < 8; i++) mem_model[a + 32'(i * 4)] = d[i*32 +: 32];
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
      end
    end
  end

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [4:0]  idx;
    logic [21:0] tg;
    bit          hit;
    bit          dirty_evict;
    logic [31:0] exp_rd;
    int          cyc;
    idx         = addr[9:5];
    tg          = addr[31:10];
    hit         = res_valid[idx] && (res_tag[idx] == tg);
    dirty_evict = !hit && res_valid[idx] && res_dirty[idx];
    exp_rd      = arch_word(addr);
    txn_q.delete();
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    @(negedge clk_i);
    chk("stall_first", 256'(cpu_stall_o), 256'(!hit));
    cyc = 0;
    while (cpu_stall_o && cyc < 64) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("miss_done", 256'(cpu_stall_o), 256'(0));
    chk("rdata", 256'(cpu_rdata_o), 256'(we ? 32'd0 : exp_rd));
    chk("ntxn", 256'(txn_q.size()), 256'(hit ? 0 : (dirty_evict ? 2 : 1)));
    if (dirty_evict && txn_q.size() >= 1)
      chk("wb_addr", 256'(txn_q[0]), 256'({1'b1, res_tag[idx], idx, 5'b0}));
    if (!hit && txn_q.size() >= 1)
      chk("fill_addr", 256'(txn_q[txn_q.size()-1]), 256'({1'b0, tg, idx, 5'b0}));
    @(posedge clk_i); #1;
    if (we) shadow[addr] = wdata;
    res_dirty[idx] = (hit && res_dirty[idx]) || we;
    res_valid[idx] = 1'b1;
    res_tag[idx]   = tg;
    exp_acc++;
    if (!hit) exp_miss++;
  endtask

  task automatic idle_cycle();
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    chk("idle", 256'({cpu_stall_o, cpu_rdata_o, mem_req_o}), 256'(0));
    @(posedge clk_i); #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    chk({tag, "_acc"}, 256'(access_cnt_o), 256'(exp_acc));
    chk({tag, "_miss"}, 256'(miss_cnt_o), 256'(exp_miss));
`else
    chk({tag, "_nostats"}, 256'(cpu_stall_o), 256'(0));
`endif
  endtask

  initial begin
    logic [31:0] a;
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    resp_en     = 1'b1;
    model_reset();
    mem_model[32'h404] = 32'h1111_2222;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", 256'({cpu_stall_o, cpu_rdata_o, mem_req_o, mem_we_o}), 256'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_stats("rst");

    do_access(1'b0, 32'h400, 32'h0);
    do_access(1'b0, 32'h404, 32'h0);
    chk("word1_fill", 256'(arch_word(32'h404)), 256'(32'h1111_2222));
    do_access(1'b1, 32'h404, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h404, 32'h0);
    do_access(1'b0, 32'h804, 32'h0);
    check_stats("dir");
`ifdef DCACHE_STATS_EN
    chk("acc_is_5", 256'(access_cnt_o), 256'(5));
    chk("miss_is_2", 256'(miss_cnt_o), 256'(2));
`endif
    do_access(1'b0, 32'hC00, 32'h0);
    do_access(1'b1, 32'hC04, 32'hCAFE_F00D);
    idle_cycle();

    // Reset during a write-back, followed by a stale ack
    resp_en     = 1'b0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h404;
    @(negedge clk_i);
    chk("wb_stall", 256'(cpu_stall_o), 256'(1));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("wb_req", 256'({mem_req_o, mem_we_o, mem_addr_o}), 256'({2'b11, 32'hC00}));
    chk("wb_word1", 256'(mem_wdata_o[63:32]), 256'(32'hCAFE_F00D));
    @(posedge clk_i); #1;
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    mem_ack_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    chk("rst_req_drop", 256'({mem_req_o, cpu_stall_o}), 256'(0));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_ign", 256'({mem_req_o, cpu_stall_o}), 256'(0));
    @(posedge clk_i); #1;
    resp_en = 1'b1;
    check_stats("rst2");
    do_access(1'b0, 32'h400, 32'h0);

    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      do_access(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
    idle_cycle();
    check_stats("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
